candidate_feeder: RTL and testbench
===================================

# candidate_feeder

Upstream stimulus stage for the cypher-search top level: it enumerates 16-bit candidate codes and serialises each one, MSB nibble first, onto the 4-bit digit input with a one-cycle `read` strobe per nibble. After each candidate it opens a response window and samples the consumer's `find` flag. It stops on the first hit, latching the matching code, or after the full code space is exhausted.

## Interface
Parameters:
- `START_CODE`, default 16'h0000: first candidate after `start`.
- `GAP`, default 1: idle cycles (`read`=0) between consecutive nibbles of one candidate; legal range 0..15.
- `FIND_WAIT`, default 4: length in cycles of the response window after the 4th nibble; legal range 1..15.

Ports:
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin a search; sampled only in IDLE or DONE.
- `find` in 1: hit flag from the downstream checker; sampled only in WAIT.
- `four_bit_input` out 4: current nibble; valid only while `read`=1.
- `read` out 1: one-cycle strobe, one per nibble.
- `busy` out 1: high in SEND/GAP/WAIT.
- `done` out 1: high in DONE.
- `found` out 1: in DONE, 1 = hit, 0 = exhausted.
- `found_code` out 16: candidate that produced the hit.
- `attempts` out 17: number of candidates fully sent since the last `start`.

## Operation
- All outputs are registered. Reset value is 0 for every output; the state goes to IDLE and internal counters clear.
- States are IDLE, SEND, GAP, WAIT, DONE.
- **IDLE / DONE, `start`=1:**
  - Load candidate ← `START_CODE`, nibble index ← 0.
  - Clear `done`, `found`, `attempts`; keep `found_code`.
  - Go to SEND.
- **SEND:**
  - Drive `read`=1 and `four_bit_input` = candidate[15:12], [11:8], [7:4], [3:0] for index 0..3.
  - Index <3: go to GAP, or straight back to SEND if `GAP`=0.
  - Index 3: `attempts` += 1, go to WAIT.
- **GAP:** `read`=0 for `GAP` cycles, then go to SEND with index+1.
- **WAIT:** `read`=0 for up to `FIND_WAIT` cycles, sampling `find` every cycle.
  - `find`=1 → DONE with `found`=1 and `found_code` ← candidate.
  - Window expires and candidate ≠ 16'hFFFF → candidate += 1, index ← 0, go to SEND.
  - Window expires and candidate = 16'hFFFF → DONE with `found`=0 (no wrap to 0).
- **DONE:** hold all outputs and `read`=0 until `start` or `reset`.
- `find` outside WAIT is ignored.
- `start` in SEND/GAP/WAIT is ignored.
- `reset` mid-search aborts the search immediately; there is no partial strobe after reset.
- `attempts` is 17 bits, max 65536; it never wraps within one search.

## Timing
- `start` sampled high at edge 0 → first `read`=1 in cycle 1.
- Cycles per candidate without a hit: 4 + 3·`GAP` + `FIND_WAIT`.
- Defaults: `read` in cycles 1, 3, 5, 7; WAIT in cycles 8–11; next candidate's first `read` in cycle 12 (period 11).
- `find` sampled in WAIT cycle k → `done`=1, `busy`=0 in cycle k+1.
- A full exhausting search from `START_CODE`=0 with defaults takes 65536·11 cycles; `done` rises the cycle after the last WAIT cycle.
- `busy` and `done` are never both high.
- `read` is never high outside SEND.

## Test plan
- Reset, then idle → all outputs 0, `read` never pulses with no `start`.
- Defaults, `start`, checker asserts `find` in the 2nd WAIT cycle of candidate 16'h0003 → nibbles 0,0,0,3 strobed; `done`=1, `found`=1, `found_code`=16'h0003, `attempts`=4.
- `START_CODE`=16'hFFFE, `find` tied 0 → candidates FFFE and FFFF sent; `done`=1, `found`=0, `attempts`=2, no wrap to 0000.
- `GAP`=0, `FIND_WAIT`=1, `start` → `read` high in cycles 1–4 for one candidate, WAIT in cycle 5, next candidate's `read` in cycle 6.
- `find` pulsed during SEND/GAP, plus `start` pulsed mid-search → both ignored; candidate sequence unchanged.
- `reset` asserted in the GAP after the 2nd nibble → next cycle all outputs 0 and state IDLE; a new `start` restarts from `START_CODE` with `attempts`=0.

Source files
------------

// File: rtl/candidate_feeder.sv
// candidate_feeder: enumerates 16-bit candidate codes from START_CODE and sends
// each one MSB nibble first on four_bit_input with a one-cycle read strobe per
// nibble. After the fourth nibble it waits up to FIND_WAIT cycles for find.
// It stops on the first hit, or after candidate 16'hFFFF with no hit.
//
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   start            : begin a search (honoured in IDLE/DONE only)
//   find             : hit flag from the checker (honoured in WAIT only)
//   four_bit_input   : current nibble, valid while read=1
//   read             : one-cycle strobe per nibble
//   busy / done      : search running / search finished
//   found            : in DONE, 1 = hit, 0 = code space exhausted
//   found_code       : candidate that produced the hit
//   attempts         : candidates fully sent since the last start
module candidate_feeder #(
    parameter logic [15:0] START_CODE = 16'h0000,
    parameter int unsigned GAP        = 1,
    parameter int unsigned FIND_WAIT  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        find,
    output logic [3:0]  four_bit_input,
    output logic        read,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [15:0] found_code,
    output logic [16:0] attempts
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FIND_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_cand;
    logic [15:0]      w_cand_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_found;
    logic             w_found_nxt;
    logic [15:0]      r_found_code;
    logic [15:0]      w_found_code_nxt;
    logic [16:0]      r_attempts;
    logic [16:0]      w_attempts_nxt;
    logic [3:0]       w_nib_nxt;
    logic             r_read;
    logic [3:0]       r_nib;
    logic             r_busy;
    logic             r_done;

    // Next-state and datapath updates; the cycle counter restarts on every state change.
    always_comb begin
        w_state_nxt      = r_state;
        w_cand_nxt       = r_cand;
        w_idx_nxt        = r_idx;
        w_cnt_nxt        = '0;
        w_found_nxt      = r_found;
        w_found_code_nxt = r_found_code;
        w_attempts_nxt   = r_attempts;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt    = S_SEND;
                    w_cand_nxt     = START_CODE;
                    w_idx_nxt      = 2'd0;
                    w_found_nxt    = 1'b0;
                    w_attempts_nxt = '0;
                end
            end
            S_SEND: begin
                if (r_idx == 2'd3) begin
                    w_attempts_nxt = r_attempts + 17'd1;
                    w_state_nxt    = S_WAIT;
                end else if (GAP == 0) begin
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (find) begin
                    w_state_nxt      = S_DONE;
                    w_found_nxt      = 1'b1;
                    w_found_code_nxt = r_cand;
                end else if (r_cnt == WAIT_LAST) begin
                    // Last candidate ends the search rather than wrapping to 0.
                    if (r_cand == 16'hFFFF) begin
                        w_state_nxt = S_DONE;
                        w_found_nxt = 1'b0;
                    end else begin
                        w_cand_nxt  = r_cand + 16'd1;
                        w_idx_nxt   = 2'd0;
                        w_state_nxt = S_SEND;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Nibble that the next SEND cycle will present, MSB first.
    always_comb begin
        w_nib_nxt = 4'h0;
        case (w_idx_nxt)
            2'd0:    w_nib_nxt = w_cand_nxt[15:12];
            2'd1:    w_nib_nxt = w_cand_nxt[11:8];
            2'd2:    w_nib_nxt = w_cand_nxt[7:4];
            default: w_nib_nxt = w_cand_nxt[3:0];
        endcase
    end

    // State, datapath and outputs; outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cand       <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_found      <= 1'b0;
            r_found_code <= '0;
            r_attempts   <= '0;
            r_read       <= 1'b0;
            r_nib        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_found      <= w_found_nxt;
            r_found_code <= w_found_code_nxt;
            r_attempts   <= w_attempts_nxt;
            r_read       <= (w_state_nxt == S_SEND);
            r_nib        <= (w_state_nxt == S_SEND) ? w_nib_nxt : 4'h0;
            r_busy       <= (w_state_nxt == S_SEND) || (w_state_nxt == S_GAP) ||
                            (w_state_nxt == S_WAIT);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    assign four_bit_input = r_nib;
    assign read           = r_read;
    assign busy           = r_busy;
    assign done           = r_done;
    assign found          = r_found;
    assign found_code     = r_found_code;
    assign attempts       = r_attempts;

endmodule

// File: tb/tb_candidate_feeder.sv
// Bench for candidate_feeder: three instances with different parameters, an
// arithmetic reference model (position within a search derived from cycles
// since start), a per-cycle compare process and a few literal checks.
module tb_candidate_feeder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst   [3];
    logic        st    [3];
    logic        fd    [3];
    logic [3:0]  o_nib [3];
    logic        o_read[3];
    logic        o_busy[3];
    logic        o_done[3];
    logic        o_fnd [3];
    logic [15:0] o_fc  [3];
    logic [16:0] o_att [3];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    candidate_feeder #(.START_CODE(16'h0000), .GAP(1), .FIND_WAIT(4)) dut_a (
        .clock(clock), .reset(rst[0]), .start(st[0]), .find(fd[0]),
        .four_bit_input(o_nib[0]), .read(o_read[0]), .busy(o_busy[0]), .done(o_done[0]),
        .found(o_fnd[0]), .found_code(o_fc[0]), .attempts(o_att[0]));

    candidate_feeder #(.START_CODE(16'hFFFE), .GAP(1), .FIND_WAIT(4)) dut_b (
        .clock(clock), .reset(rst[1]), .start(st[1]), .find(fd[1]),
        .four_bit_input(o_nib[1]), .read(o_read[1]), .busy(o_busy[1]), .done(o_done[1]),
        .found(o_fnd[1]), .found_code(o_fc[1]), .attempts(o_att[1]));

    candidate_feeder #(.START_CODE(16'hABCD), .GAP(0), .FIND_WAIT(1)) dut_c (
        .clock(clock), .reset(rst[2]), .start(st[2]), .find(fd[2]),
        .four_bit_input(o_nib[2]), .read(o_read[2]), .busy(o_busy[2]), .done(o_done[2]),
        .found(o_fnd[2]), .found_code(o_fc[2]), .attempts(o_att[2]));

    function automatic int gp(input int d);
        return (d == 2) ? 0 : 1;
    endfunction

    function automatic int wt(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic logic [15:0] sc(input int d);
        case (d)
            0:       return 16'h0000;
            1:       return 16'hFFFE;
            default: return 16'hABCD;
        endcase
    endfunction

    function automatic int period(input int d);
        return 4 + 3 * gp(d) + wt(d);
    endfunction

    // Model state: running flag, cycles since start (1 = first SEND cycle), end result.
    bit          m_run  [3];
    int          m_t    [3];
    bit          m_done [3];
    bit          m_found[3];
    logic [15:0] m_fc   [3];
    int          m_att  [3];

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; st[d] = 1'b0; fd[d] = 1'b0;
            m_run[d] = 1'b0; m_t[d] = 0; m_done[d] = 1'b0;
            m_found[d] = 1'b0; m_fc[d] = 16'h0; m_att[d] = 0;
        end
    end

    function automatic bit in_wait(input int d);
        int r;
        if (!m_run[d]) return 1'b0;
        r = (m_t[d] - 1) % period(d);
        return r >= 3 * gp(d) + 4;
    endfunction

    always @(posedge clock) begin
        for (int d = 0; d < 3; d++) begin
            int p, r, k;
            logic [15:0] c;
            p = period(d);
            if (rst[d]) begin
                m_run[d] = 1'b0; m_t[d] = 0; m_done[d] = 1'b0;
                m_found[d] = 1'b0; m_fc[d] = 16'h0; m_att[d] = 0;
            end else if (!m_run[d]) begin
                if (st[d]) begin
                    m_run[d] = 1'b1; m_t[d] = 1; m_done[d] = 1'b0; m_found[d] = 1'b0;
                end
            end else begin
                r = (m_t[d] - 1) % p;
                k = (m_t[d] - 1) / p;
                c = sc(d) + 16'(k);
                if (r >= 3 * gp(d) + 4 && fd[d]) begin
                    m_run[d] = 1'b0; m_done[d] = 1'b1; m_found[d] = 1'b1;
                    m_fc[d] = c; m_att[d] = k + 1;
                end else if (r == p - 1 && c == 16'hFFFF) begin
                    m_run[d] = 1'b0; m_done[d] = 1'b1; m_found[d] = 1'b0;
                    m_att[d] = k + 1;
                end else begin
                    m_t[d] = m_t[d] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d @%0t: got %0h want %0h", nm, d, $time, act, exp);
        end
    endtask

    // Per-cycle compare of every DUT against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                int r, k, s;
                logic [15:0] c;
                bit e_rd, e_busy, e_done, e_fnd;
                logic [3:0] e_nib;
                int e_att;
                e_rd = 1'b0; e_nib = 4'h0; e_busy = 1'b0;
                e_done = m_done[d]; e_fnd = m_found[d]; e_att = m_att[d];
                if (m_run[d]) begin
                    s = gp(d) + 1;
                    r = (m_t[d] - 1) % period(d);
                    k = (m_t[d] - 1) / period(d);
                    c = sc(d) + 16'(k);
                    e_rd = (r <= 3 * s) && (r % s == 0);
                    e_nib = 4'(c >> (12 - 4 * (r / s)));
                    e_busy = 1'b1; e_done = 1'b0; e_fnd = 1'b0;
                    e_att = k + ((r >= 3 * gp(d) + 4) ? 1 : 0);
                end
                chk("read", d, 32'(o_read[d]), 32'(e_rd));
                if (e_rd) chk("nibble", d, 32'(o_nib[d]), 32'(e_nib));
                chk("busy", d, 32'(o_busy[d]), 32'(e_busy));
                chk("done", d, 32'(o_done[d]), 32'(e_done));
                chk("found", d, 32'(o_fnd[d]), 32'(e_fnd));
                chk("found_code", d, 32'(o_fc[d]), 32'(m_fc[d]));
                chk("attempts", d, 32'(o_att[d]), 32'(e_att));
            end
        end
    end

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic rand_run(input int d, input int n);
        st[d] = 1'b1;
        cyc();
        st[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            fd[d] = in_wait(d) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
            st[d] = ($urandom_range(0, 9) == 0);
            cyc();
        end
        fd[d] = 1'b0; st[d] = 1'b0;
        rst[d] = 1'b1;
        cyc();
        rst[d] = 1'b0;
    endtask

    initial begin
        logic [3:0] q[$];
        int n;

        cyc();
        chk_en = 1'b1;
        cyc();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Reset values, then idle with no start.
        chk("rst_read", 0, 32'(o_read[0]), 32'd0);
        chk("rst_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("rst_done", 0, 32'(o_done[0]), 32'd0);
        chk("rst_attempts", 0, 32'(o_att[0]), 32'd0);
        for (int i = 0; i < 10; i++) cyc();

        // Hit on candidate 0003 in its 2nd WAIT cycle.
        st[0] = 1'b1;
        cyc();
        st[0] = 1'b0;
        chk("first_read", 0, 32'(o_read[0]), 32'd1);
        for (int i = 0; i < 42; i++) begin
            if (o_read[0]) q.push_back(o_nib[0]);
            if (i == 41) fd[0] = 1'b1;
            cyc();
        end
        fd[0] = 1'b0;
        chk("hit_done", 0, 32'(o_done[0]), 32'd1);
        chk("hit_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("hit_found", 0, 32'(o_fnd[0]), 32'd1);
        chk("hit_code", 0, 32'(o_fc[0]), 32'h0003);
        chk("hit_attempts", 0, 32'(o_att[0]), 32'd4);
        chk("strobe_count", 0, 32'(q.size()), 32'd16);
        if (q.size() == 16) begin
            chk("nib12", 0, 32'(q[12]), 32'd0);
            chk("nib14", 0, 32'(q[14]), 32'd0);
            chk("nib15", 0, 32'(q[15]), 32'd3);
        end
        fd[0] = 1'b1;
        cyc();
        fd[0] = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        // Reset in the GAP after the 2nd nibble, then restart.
        st[0] = 1'b1;
        cyc();
        st[0] = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("gap_read", 0, 32'(o_read[0]), 32'd0);
        rst[0] = 1'b1;
        cyc();
        rst[0] = 1'b0;
        chk("abort_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("abort_code", 0, 32'(o_fc[0]), 32'd0);
        st[0] = 1'b1;
        cyc();
        st[0] = 1'b0;
        chk("restart_nib", 0, 32'(o_nib[0]), 32'd0);
        chk("restart_att", 0, 32'(o_att[0]), 32'd0);
        for (int i = 0; i < 8; i++) cyc();
        chk("restart_att1", 0, 32'(o_att[0]), 32'd1);

        // Exhaust from FFFE: two candidates, no wrap.
        st[1] = 1'b1;
        cyc();
        st[1] = 1'b0;
        n = 0;
        while (!m_done[1] && n < 100) begin
            cyc();
            n++;
        end
        chk("exhaust_bound", 1, 32'(n < 100), 32'd1);
        chk("exhaust_cycles", 1, 32'(n), 32'd22);
        chk("exhaust_done", 1, 32'(o_done[1]), 32'd1);
        chk("exhaust_found", 1, 32'(o_fnd[1]), 32'd0);
        chk("exhaust_att", 1, 32'(o_att[1]), 32'd2);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_read[1]) n++;
            cyc();
        end
        chk("no_wrap_reads", 1, 32'(n), 32'd0);

        // GAP=0, FIND_WAIT=1 timing.
        st[2] = 1'b1;
        cyc();
        st[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("g0_read", 2, 32'(o_read[2]), 32'd1);
            chk("g0_nib", 2, 32'(o_nib[2]), 32'(4'hA + 4'(i)));
            cyc();
        end
        chk("g0_wait_read", 2, 32'(o_read[2]), 32'd0);
        chk("g0_wait_busy", 2, 32'(o_busy[2]), 32'd1);
        cyc();
        chk("g0_next_read", 2, 32'(o_read[2]), 32'd1);
        chk("g0_next_att", 2, 32'(o_att[2]), 32'd1);
        rst[2] = 1'b1;
        cyc();
        rst[2] = 1'b0;

        // Randomized find/start activity, checked per cycle against the model.
        for (int j = 0; j < 3; j++) begin
            rand_run(0, 400);
            rand_run(1, 200);
            rand_run(2, 400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
